// File: rtl/pc_run_sequencer_if.sv
// pc_run_sequencer_if
//   Bundles the run-control handshake and the PC/next-PC bus between the
//   miniMips decode/ALU side and pc_run_sequencer.
//   master : drives start/halt/stall/branch/jump, observes pc and status.
//   slave  : the sequencer itself.
//   Signals:
//     start, halt, stall          run-control inputs to the sequencer
//     branch_taken, branch_off    relative branch request (signed offset)
//     jump_en, jump_target        absolute jump request
//     pc, instr_valid, busy, done sequencer outputs
//     retire_count                retired-instruction counter (RETIRE_CNT_EN only)
interface pc_run_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 6
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             branch_taken;
  logic [OFF_W-1:0] branch_off;
  logic             jump_en;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             busy;
  logic             done;
`ifdef RETIRE_CNT_EN
  logic [15:0]      retire_count;
`endif

  modport master (
    output start, halt, stall, branch_taken, branch_off, jump_en, jump_target,
    input  pc, instr_valid, busy, done
`ifdef RETIRE_CNT_EN
    , input retire_count
`endif
  );

  modport slave (
    input  start, halt, stall, branch_taken, branch_off, jump_en, jump_target,
    output pc, instr_valid, busy, done
`ifdef RETIRE_CNT_EN
    , output retire_count
`endif
  );
endinterface

// File: rtl/pc_run_sequencer.sv
// pc_run_sequencer
//   Run-control and program-counter sequencer for the 9-bit miniMips core.
//   Owns the start/done handshake and drives the instruction ROM address.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    pc_run_sequencer_if.slave (start/halt/stall/branch/jump in,
//            pc/instr_valid/busy/done out)
//   Optional feature: define RETIRE_CNT_EN to add a saturating 16-bit
//   retired-instruction counter (bus.retire_count).
//   Next-PC priority in RUN (when not stalled): halt > jump > branch > +1.
//   Sequential advance past the last ROM entry ends the run instead of wrapping.
module pc_run_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned OFF_W    = 6,
  parameter int unsigned RESET_PC = 0
) (
  input logic                clk,
  input logic                rst_n,
  pc_run_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_off_ext;
  logic            busy, done, instr_valid;

  assign br_off_ext = {{(PC_W-OFF_W){bus.branch_off[OFF_W-1]}}, bus.branch_off};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state / next-PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = PC_RST;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.jump_en) begin
            pc_d = bus.jump_target;
          end else if (bus.branch_taken) begin
            pc_d = pc_q + br_off_ext;
          end else if (pc_q == '1) begin
            // Ran off the end of the ROM: finish, keep last address.
            state_d = DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = PC_RST;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = PC_RST;
      end
    endcase
  end

  // Outputs decoded from registered state; instr_valid also gates on stall.
  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    instr_valid = (state_q == RUN) && !bus.stall;
  end

  assign bus.pc          = pc_q;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.instr_valid = instr_valid;

`ifdef RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.start && (state_q != RUN)) cnt_d = '0;
    else if (instr_valid && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  assign bus.retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_run_sequencer.sv
module tb_pc_run_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  pc_run_sequencer_if #(.PC_W(8), .OFF_W(6)) bus();

  pc_run_sequencer #(.PC_W(8), .OFF_W(6), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: "running" / "finished" flags, PC as an integer.
  bit mrun, mfin;
  int mpc, mcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mrun = 0; mfin = 0; mpc = 0; mcnt = 0;
  endfunction

  function automatic void model_edge();
    int off;
    if (!rst_n) begin
      model_reset();
    end else if (mrun) begin
      if (!bus.stall) begin
        if (mcnt < 65535) mcnt++;
        off = int'(bus.branch_off);
        if (off >= 32) off -= 64;
        if (bus.halt) begin mrun = 0; mfin = 1; end
        else if (bus.jump_en) mpc = int'(bus.jump_target);
        else if (bus.branch_taken) mpc = ((mpc + off) % 256 + 256) % 256;
        else if (mpc == 255) begin mrun = 0; mfin = 1; end
        else mpc++;
      end
    end else if (bus.start) begin
      mrun = 1; mfin = 0; mpc = 0; mcnt = 0;
    end
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".pc"},   32'(bus.pc),   32'(mpc));
    check({tag, ".busy"}, 32'(bus.busy), 32'(mrun));
    check({tag, ".done"}, 32'(bus.done), 32'(mfin));
`ifdef RETIRE_CNT_EN
    check({tag, ".cnt"},  32'(bus.retire_count), 32'(mcnt));
`endif
  endtask

  // Apply inputs (called just after a negedge) and check the combinational valid.
  task automatic drive(input bit st, input bit hl, input bit sl, input bit br,
                       input logic [5:0] off, input bit jp, input logic [7:0] tgt);
    bus.start = st; bus.halt = hl; bus.stall = sl; bus.branch_taken = br;
    bus.branch_off = off; bus.jump_en = jp; bus.jump_target = tgt;
    #1;
    check("instr_valid", 32'(bus.instr_valid), 32'(mrun && !sl && rst_n));
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 6'd0, 0, 8'd0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs(tag);
  endtask

  initial begin
    model_reset();
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.branch_off = '0; bus.jump_en = 0; bus.jump_target = '0;
    repeat (2) @(negedge clk);
    check_regs("reset");
    rst_n = 1'b1;

    // Start pulse, straight-line run, halt at pc=5.
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("start");
    check("first_pc", 32'(bus.pc), 32'd0);
    idle_in();
    for (int unsigned i = 0; i < 5; i++) tick("seq");
    check("pc5", 32'(bus.pc), 32'd5);
    drive(0, 1, 0, 0, 6'd0, 0, 8'd0); tick("halt");
    check("halt_done", 32'(bus.done), 32'd1);
    check("halt_pc", 32'(bus.pc), 32'd5);
`ifdef RETIRE_CNT_EN
    check("retire6", 32'(bus.retire_count), 32'd6);
`endif
    idle_in(); tick("done_hold");
    check("done_hold_pc", 32'(bus.pc), 32'd5);

    // Branches forward/backward, then stall with pending branch.
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("restart");
    idle_in(); tick("seq"); tick("seq");
    drive(0, 0, 0, 1, 6'd2, 0, 8'd0); tick("br_fwd");
    check("br_fwd_pc", 32'(bus.pc), 32'd4);
    drive(0, 0, 0, 1, 6'b111110, 0, 8'd0); tick("br_back");
    check("br_back_pc", 32'(bus.pc), 32'd2);
    idle_in(); tick("seq");
    for (int unsigned i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 6'd5, 0, 8'd0);
      check("stall_valid", 32'(bus.instr_valid), 32'd0);
      tick("stall");
      check("stall_pc", 32'(bus.pc), 32'd3);
    end
    drive(0, 0, 0, 1, 6'd5, 0, 8'd0); tick("br_after_stall");
    check("br_after_stall_pc", 32'(bus.pc), 32'd8);
    drive(0, 0, 0, 1, 6'd0, 0, 8'd0); tick("self_loop");
    check("self_loop_pc", 32'(bus.pc), 32'd8);

    // Priority: halt beats jump and branch; jump beats branch.
    drive(0, 1, 0, 1, 6'd3, 1, 8'h77); tick("prio_halt");
    check("prio_halt_done", 32'(bus.done), 32'd1);
    check("prio_halt_pc", 32'(bus.pc), 32'd8);
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("restart2");
    drive(0, 0, 0, 1, 6'd3, 1, 8'h40); tick("prio_jump");
    check("prio_jump_pc", 32'(bus.pc), 32'h40);
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("start_in_run");
    check("start_ignored_pc", 32'(bus.pc), 32'h41);

    // Full ROM run from RESET_PC with no halt: ends at 0xFF without wrapping.
    drive(0, 1, 0, 0, 6'd0, 0, 8'd0); tick("halt2");
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("restart3");
    idle_in();
    for (int unsigned i = 0; i < 255; i++) tick("rom");
    check("rom_last_pc", 32'(bus.pc), 32'hFF);
    tick("rom_end");
    check("rom_end_done", 32'(bus.done), 32'd1);
    check("rom_end_pc", 32'(bus.pc), 32'hFF);
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("restart4");
    check("restart_pc", 32'(bus.pc), 32'd0);
    check("restart_done", 32'(bus.done), 32'd0);

    // Branch arithmetic wraps: 0 - 1 = 0xFF.
    drive(0, 0, 0, 1, 6'b111111, 0, 8'd0); tick("br_wrap");
    check("br_wrap_pc", 32'(bus.pc), 32'hFF);

    // Asynchronous reset mid-run at pc=0x23.
    drive(0, 0, 0, 0, 6'd0, 1, 8'h23); tick("jmp23");
    check("pc23", 32'(bus.pc), 32'h23);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    @(negedge clk);
    drive(1, 0, 0, 0, 6'd0, 0, 8'd0); tick("start_in_rst");
    check("start_in_rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle_in(); tick("post_rst");

    // Randomized phase against the model.
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [7:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom);
      drive($urandom_range(0, 9) < 2, $urandom_range(0, 39) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            6'($urandom), $urandom_range(0, 9) == 0, tgt);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
